// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared ROB constants, CDB packet and ROB entry structs
package rob_pkg;

    localparam int TAG_W = 4;
    localparam int DEPTH = 1 << TAG_W;

    // Result broadcast from the common data bus
    typedef struct packed {
        logic             cdb_valid;
        logic [TAG_W-1:0] cdb_rob_tag;
        logic [31:0]      cdb_data;
        logic [31:0]      cdb_store_data;
    } cdb_packed_s;

    // One reorder-buffer slot
    typedef struct packed {
        logic        valid;
        logic        done;
        logic [4:0]  rd;
        logic        is_store;
        logic        is_branch;
        logic [31:0] data;
        logic [31:0] store_data;
    } rob_entry_s;

endpackage

// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer with in-order commit and taken-branch flush
module rob
    import rob_pkg::*;
#(
    parameter int DEPTH = rob_pkg::DEPTH,
    parameter int TAG_W = rob_pkg::TAG_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dispatch_valid_i,
    input  logic [4:0]        dispatch_rd_i,
    input  logic              dispatch_is_store_i,
    input  logic              dispatch_is_branch_i,
    output logic              dispatch_ready_o,
    output logic [TAG_W-1:0]  dispatch_tag_o,
    input  cdb_packed_s       packed_cdb_packet,
    output logic              commit_valid_o,
    input  logic              commit_ready_i,
    output logic [TAG_W-1:0]  commit_tag_o,
    output logic [4:0]        commit_rd_o,
    output logic [31:0]       commit_data_o,
    output logic [31:0]       commit_store_data_o,
    output logic              commit_is_store_o,
    output logic              flush_o
);

    rob_entry_s       r_entries [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;
    logic             r_flush;

    rob_entry_s       w_head;
    logic             w_dispatch;
    logic             w_commit;
    logic             w_taken;
    logic             w_cdb_hit;

    assign w_head           = r_entries[r_head];
    assign dispatch_ready_o = (r_count != (TAG_W+1)'(DEPTH)) && !r_flush;
    assign dispatch_tag_o   = r_tail;
    assign commit_valid_o   = w_head.valid && w_head.done && !r_flush;
    assign commit_tag_o        = r_head;
    assign commit_rd_o         = w_head.rd;
    assign commit_data_o       = w_head.data;
    assign commit_store_data_o = w_head.store_data;
    assign commit_is_store_o   = w_head.is_store;
    assign flush_o             = r_flush;

    assign w_dispatch = dispatch_valid_i && dispatch_ready_o;
    assign w_commit   = commit_valid_o && commit_ready_i;
    // Branches are predicted not-taken, so a retiring branch whose result bit 0 is set was mispredicted
    assign w_taken    = w_commit && w_head.is_branch && w_head.data[0];
    // Results for slots that are not allocated are stale broadcasts and must be dropped
    assign w_cdb_hit  = packed_cdb_packet.cdb_valid && r_entries[packed_cdb_packet.cdb_rob_tag].valid;

    // Entry array, pointers, occupancy and the one-cycle flush flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flush <= 1'b0;
        end else if (r_flush) begin
            // Squash cycle: every in-flight entry is younger than the mispredicted branch
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flush <= 1'b0;
        end else begin
            if (w_cdb_hit) begin
                r_entries[packed_cdb_packet.cdb_rob_tag].done       <= 1'b1;
                r_entries[packed_cdb_packet.cdb_rob_tag].data       <= packed_cdb_packet.cdb_data;
                r_entries[packed_cdb_packet.cdb_rob_tag].store_data <= packed_cdb_packet.cdb_store_data;
            end
            if (w_dispatch) begin
                r_entries[r_tail] <= '{valid: 1'b1, done: 1'b0, rd: dispatch_rd_i,
                                       is_store: dispatch_is_store_i,
                                       is_branch: dispatch_is_branch_i,
                                       data: 32'd0, store_data: 32'd0};
                r_tail <= r_tail + 1'b1;
            end
            // Placed after the CDB update so retiring wins over a late rebroadcast to the head
            if (w_commit) begin
                r_entries[r_head].valid <= 1'b0;
                r_head <= r_head + 1'b1;
            end
            if (w_dispatch && !w_commit) begin
                r_count <= r_count + 1'b1;
            end else if (w_commit && !w_dispatch) begin
                r_count <= r_count - 1'b1;
            end
            r_flush <= w_taken;
        end
    end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of reorder-buffer entries; it SHALL equal 2**TAG_W.
REQ-002 Parameter TAG_W, default 4, meaning ROB tag width; it SHALL match cdb_rob_tag width.
REQ-003 clk_i  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 reset_i  input  1  meaning synchronous, active-high reset.
REQ-005 dispatch_valid_i  input  1  meaning an instruction requests ROB allocation this cycle.
REQ-006 dispatch_rd_i  input  5  meaning destination architectural register (0 = none).
REQ-007 dispatch_is_store_i  input  1  meaning the dispatched instruction is a store.
REQ-008 dispatch_is_branch_i  input  1  meaning the dispatched instruction is a conditional branch.
REQ-009 dispatch_ready_o  output  1  meaning allocation is accepted this cycle.
REQ-010 dispatch_tag_o  output  TAG_W  meaning the tag assigned to the current dispatch (tail pointer).
REQ-011 packed_cdb_packet  input  cdb_packed_s  meaning the CDB broadcast (cdb_valid, cdb_rob_tag, cdb_data, cdb_store_data).
REQ-012 commit_valid_o  output  1  meaning the head entry is complete and presented for retirement.
REQ-013 commit_ready_i  input  1  meaning the register file/store path accepts the commit.
REQ-014 commit_tag_o, commit_rd_o, commit_data_o, commit_store_data_o, commit_is_store_o  outputs  TAG_W/5/32/32/1  meaning the fields of the head entry.
REQ-015 flush_o  output  1  meaning a taken branch retired; downstream state SHALL be squashed.

Function
REQ-016 dispatch_ready_o SHALL equal (count != DEPTH) AND NOT flush_o.
REQ-017 On dispatch_valid_i AND dispatch_ready_o: entry[tail] SHALL be written valid=1, done=0, rd, is_store, is_branch; tail SHALL increment modulo DEPTH.
REQ-018 On cdb_valid with entry[cdb_rob_tag].valid=1: that entry SHALL set done=1 and capture cdb_data and cdb_store_data; a CDB write to an invalid entry SHALL be ignored.
REQ-019 commit_valid_o SHALL equal entry[head].valid AND entry[head].done AND NOT flush_o; commit outputs are combinational from entry[head].
REQ-020 Commit handshake: commit_valid_o AND commit_ready_i SHALL clear entry[head].valid and increment head modulo DEPTH.
REQ-021 A CDB write to the head entry SHALL make it committable no earlier than the following cycle (no CDB-to-commit bypass).
REQ-022 count SHALL be (TAG_W+1) bits: +1 on dispatch only, -1 on commit only, unchanged when both or neither occur.
REQ-023 Branches are predicted not-taken: a committing branch with data[0]=1 SHALL assert flush_o in the next cycle for exactly one cycle; data[0]=0 commits normally.
REQ-024 During the flush_o cycle all entries SHALL be invalidated and head, tail, count SHALL become 0; dispatch and CDB inputs in that cycle SHALL be ignored.
REQ-025 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless; full (count=DEPTH) and empty (count=0) SHALL be distinguished by count, not pointer equality.

Reset
REQ-026 reset_i SHALL clear all entry valid/done bits, head, tail, count and the pending-flush flag; outputs then read dispatch_ready_o=1, dispatch_tag_o=0, commit_valid_o=0, flush_o=0, other outputs 0.
REQ-027 reset_i SHALL take priority over dispatch, CDB, commit and flush in the same cycle.

Structure
REQ-028 rob_entry_s and DEPTH/TAG_W constants SHALL live in the shared structs package alongside cdb_packed_s.
REQ-029 No sub-module; entry array, pointers and flush flag SHALL be in this module.

Verification
REQ-030 Reset, dispatch 3 (rd 1,2,3) -> tags 0,1,2; dispatch_ready_o=1, commit_valid_o=0.
REQ-031 CDB tags 2,0,1 with data 0x22,0x00,0x11, commit_ready_i=1 -> commits in order tag0/0x00, tag1/0x11, tag2/0x22.
REQ-032 Dispatch 16 without commit -> dispatch_ready_o=0 after 16th; one commit -> ready=1; tail wraps to 0.
REQ-033 Branch at tag 5 completes with data 1 and commits -> flush_o high one cycle, then count=0, dispatch_tag_o=0.
REQ-034 CDB to head in same cycle as commit_ready_i=1 -> commit_valid_o rises next cycle; CDB to an unallocated tag -> no state change.
